// File: rtl/write_back_unit_if.sv
// Execute-stage result handshake and data-memory response bundle feeding the write-back unit.
interface write_back_unit_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_y1_channel;
    logic [1:0]  ex_y2_channel;
    logic [31:0] ex_y1_data;
    logic [31:0] ex_y2_data;
    logic        ex_mem_load;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic [31:0] sys_info;

    modport master (
        output ex_valid, ex_y1_channel, ex_y2_channel, ex_y1_data, ex_y2_data,
               ex_mem_load, mem_rvalid, mem_rdata, flush, sys_info,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_y1_channel, ex_y2_channel, ex_y1_data, ex_y2_data,
               ex_mem_load, mem_rvalid, mem_rdata, flush, sys_info,
        output ex_ready
    );
endinterface

// File: rtl/write_back_unit.sv
// Final pipeline stage: decodes y1/y2 destination codes into registered per-register
// value/strobe buses, stalling the pipeline while a memory load is outstanding.
module write_back_unit (
    input  logic               clk,
    input  logic               rst,
    write_back_unit_if.slave   wb,
    output logic [31:0] back_r1, back_r2, back_r3, back_r4, back_r5, back_r6, back_r7,
    output logic [31:0] back_ds, back_flag, back_tpc, back_ipc, back_sp, back_tlb,
    output logic        back_r1_c, back_r2_c, back_r3_c, back_r4_c, back_r5_c, back_r6_c, back_r7_c,
    output logic        back_ds_c, back_flag_c, back_tpc_c, back_ipc_c, back_sp_c, back_tlb_c
);
    localparam int NREG = 13;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             lat_y1_ch;
    logic [1:0]             lat_y2_ch;
    logic [31:0]            lat_y2_data;
    logic                   commit, latch, clear_lat;
    logic [3:0]             c_y1_ch;
    logic [1:0]             c_y2_ch;
    logic [31:0]            c_y1_data, c_y2_data;
    logic [NREG-1:0]        sel1, sel2;
    logic [NREG-1:0][31:0]  back_val;
    logic [NREG-1:0]        back_stb;
    logic                   unused_sys_info;

    assign unused_sys_info = ^{wb.sys_info[31:3], wb.sys_info[1:0]};

    // Register index: 0-6 r1-r7, 7 ds, 8 flag, 9 tpc, 10 ipc, 11 sp, 12 tlb.
    function automatic logic [NREG-1:0] dec_y1(input logic [3:0] ch, input logic tlb_wp);
        logic [NREG-1:0] s;
        s = '0;
        case (ch)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: s[ch - 4'd1] = 1'b1;
            4'd8:  s[7]  = 1'b1;
            4'd9:  s[8]  = 1'b1;
            4'd11: s[9]  = 1'b1;
            4'd12: s[10] = 1'b1;
            4'd13: s[11] = 1'b1;
            4'd14: s[12] = ~tlb_wp;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [NREG-1:0] dec_y2(input logic [1:0] ch);
        logic [NREG-1:0] s;
        s = '0;
        case (ch)
            2'd1:    s[8]  = 1'b1;
            2'd2:    s[11] = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

    assign wb.ex_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        latch     = 1'b0;
        clear_lat = 1'b0;
        c_y1_ch   = wb.ex_y1_channel;
        c_y2_ch   = wb.ex_y2_channel;
        c_y1_data = wb.ex_y1_data;
        c_y2_data = wb.ex_y2_data;
        case (state)
            IDLE: begin
                // flush beats accept: the offered result simply vanishes
                if (wb.ex_valid && !wb.flush) begin
                    if (wb.ex_mem_load) begin
                        latch     = 1'b1;
                        state_nxt = WAIT_MEM;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                c_y1_ch   = lat_y1_ch;
                c_y2_ch   = lat_y2_ch;
                c_y1_data = wb.mem_rdata;
                c_y2_data = lat_y2_data;
                if (wb.flush) begin
                    clear_lat = 1'b1;
                    state_nxt = IDLE;
                end else if (wb.mem_rvalid) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sel1 = dec_y1(c_y1_ch, wb.sys_info[2]);
    assign sel2 = dec_y2(c_y2_ch);

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_y1_ch   <= '0;
            lat_y2_ch   <= '0;
            lat_y2_data <= '0;
            back_val    <= '0;
            back_stb    <= '0;
        end else begin
            if (latch) begin
                lat_y1_ch   <= wb.ex_y1_channel;
                lat_y2_ch   <= wb.ex_y2_channel;
                lat_y2_data <= wb.ex_y2_data;
            end else if (clear_lat) begin
                lat_y1_ch   <= '0;
                lat_y2_ch   <= '0;
                lat_y2_data <= '0;
            end
            back_stb <= commit ? (sel1 | sel2) : '0;
            for (int i = 0; i < NREG; i++) begin
                // y2 overrides y1 when both target the same register
                if (commit && (sel1[i] || sel2[i]))
                    back_val[i] <= sel2[i] ? c_y2_data : c_y1_data;
            end
        end
    end

    assign back_r1   = back_val[0];   assign back_r1_c   = back_stb[0];
    assign back_r2   = back_val[1];   assign back_r2_c   = back_stb[1];
    assign back_r3   = back_val[2];   assign back_r3_c   = back_stb[2];
    assign back_r4   = back_val[3];   assign back_r4_c   = back_stb[3];
    assign back_r5   = back_val[4];   assign back_r5_c   = back_stb[4];
    assign back_r6   = back_val[5];   assign back_r6_c   = back_stb[5];
    assign back_r7   = back_val[6];   assign back_r7_c   = back_stb[6];
    assign back_ds   = back_val[7];   assign back_ds_c   = back_stb[7];
    assign back_flag = back_val[8];   assign back_flag_c = back_stb[8];
    assign back_tpc  = back_val[9];   assign back_tpc_c  = back_stb[9];
    assign back_ipc  = back_val[10];  assign back_ipc_c  = back_stb[10];
    assign back_sp   = back_val[11];  assign back_sp_c   = back_stb[11];
    assign back_tlb  = back_val[12];  assign back_tlb_c  = back_stb[12];
endmodule

// File: tb/tb_write_back_unit.sv
// Randomized bench for write_back_unit against a transaction-level register-file model.
module tb_write_back_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    write_back_unit_if wb();

    logic [31:0] back_r1, back_r2, back_r3, back_r4, back_r5, back_r6, back_r7;
    logic [31:0] back_ds, back_flag, back_tpc, back_ipc, back_sp, back_tlb;
    logic back_r1_c, back_r2_c, back_r3_c, back_r4_c, back_r5_c, back_r6_c, back_r7_c;
    logic back_ds_c, back_flag_c, back_tpc_c, back_ipc_c, back_sp_c, back_tlb_c;

    write_back_unit dut (
        .clk(clk), .rst(rst), .wb(wb),
        .back_r1(back_r1), .back_r2(back_r2), .back_r3(back_r3), .back_r4(back_r4),
        .back_r5(back_r5), .back_r6(back_r6), .back_r7(back_r7), .back_ds(back_ds),
        .back_flag(back_flag), .back_tpc(back_tpc), .back_ipc(back_ipc), .back_sp(back_sp),
        .back_tlb(back_tlb),
        .back_r1_c(back_r1_c), .back_r2_c(back_r2_c), .back_r3_c(back_r3_c), .back_r4_c(back_r4_c),
        .back_r5_c(back_r5_c), .back_r6_c(back_r6_c), .back_r7_c(back_r7_c), .back_ds_c(back_ds_c),
        .back_flag_c(back_flag_c), .back_tpc_c(back_tpc_c), .back_ipc_c(back_ipc_c),
        .back_sp_c(back_sp_c), .back_tlb_c(back_tlb_c)
    );

    // Register file as seen from outside: names and the code that targets each one.
    string reg_name [13] = '{"r1","r2","r3","r4","r5","r6","r7","ds","flag","tpc","ipc","sp","tlb"};
    int    y1_target[16] = '{-1, 0, 1, 2, 3, 4, 5, 6, 7, 8, -1, 9, 10, 11, 12, -1};
    int    y2_target[4]  = '{-1, 8, 11, -1};

    logic [31:0] obs_val [13];
    logic [12:0] obs_stb;
    always_comb begin
        obs_val = '{back_r1, back_r2, back_r3, back_r4, back_r5, back_r6, back_r7,
                    back_ds, back_flag, back_tpc, back_ipc, back_sp, back_tlb};
        obs_stb = {back_tlb_c, back_sp_c, back_ipc_c, back_tpc_c, back_flag_c, back_ds_c,
                   back_r7_c, back_r6_c, back_r5_c, back_r4_c, back_r3_c, back_r2_c, back_r1_c};
    end

    // Model state
    logic [31:0] m_val [13];
    logic [12:0] m_stb;
    bit          m_busy;
    logic [3:0]  m_y1;
    logic [1:0]  m_y2;
    logic [31:0] m_y2d;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_commit(input logic [3:0] y1, input logic [1:0] y2,
                            input logic [31:0] d1, input logic [31:0] d2);
        int t1, t2;
        t1 = y1_target[y1];
        if (y1 == 4'd14 && wb.sys_info[2]) t1 = -1;
        t2 = y2_target[y2];
        if (t1 >= 0) begin m_val[t1] = d1; m_stb[t1] = 1'b1; end
        if (t2 >= 0) begin m_val[t2] = d2; m_stb[t2] = 1'b1; end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic m_edge();
        m_stb = '0;
        if (rst) begin
            foreach (m_val[i]) m_val[i] = '0;
            m_busy = 0; m_y1 = '0; m_y2 = '0; m_y2d = '0;
        end else if (!m_busy) begin
            if (wb.ex_valid && !wb.flush) begin
                if (wb.ex_mem_load) begin
                    m_busy = 1; m_y1 = wb.ex_y1_channel; m_y2 = wb.ex_y2_channel; m_y2d = wb.ex_y2_data;
                end else begin
                    m_commit(wb.ex_y1_channel, wb.ex_y2_channel, wb.ex_y1_data, wb.ex_y2_data);
                end
            end
        end else if (wb.flush) begin
            m_busy = 0; m_y1 = '0; m_y2 = '0; m_y2d = '0;
        end else if (wb.mem_rvalid) begin
            m_commit(m_y1, m_y2, wb.mem_rdata, m_y2d);
            m_busy = 0;
        end
    endtask

    task automatic cycle();
        m_edge();
        @(posedge clk);
        #1;
        chk("ex_ready", {31'd0, wb.ex_ready}, {31'd0, !m_busy});
        chk("strobes", {19'd0, obs_stb}, {19'd0, m_stb});
        for (int i = 0; i < 13; i++) chk({"back_", reg_name[i]}, obs_val[i], m_val[i]);
    endtask

    task automatic drive(input bit v, input logic [3:0] y1, input logic [31:0] d1,
                         input logic [1:0] y2, input logic [31:0] d2, input bit ld);
        wb.ex_valid = v; wb.ex_y1_channel = y1; wb.ex_y1_data = d1;
        wb.ex_y2_channel = y2; wb.ex_y2_data = d2; wb.ex_mem_load = ld;
    endtask

    task automatic idle(input int n);
        wb.ex_valid = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic rvalid(input logic [31:0] d);
        wb.mem_rvalid = 1; wb.mem_rdata = d;
        cycle();
        wb.mem_rvalid = 0;
    endtask

    initial begin
        rst = 1;
        drive(0, 0, 0, 0, 0, 0);
        wb.mem_rvalid = 0; wb.mem_rdata = 0; wb.flush = 0; wb.sys_info = 0;
        foreach (m_val[i]) m_val[i] = 'x;
        m_stb = 'x; m_busy = 0;
        cycle(); cycle();
        rst = 0;
        idle(1);

        // basic commit then hold
        drive(1, 4'd3, 32'h1234_5678, 2'd0, 0, 0); cycle();
        chk("r3_direct", back_r3, 32'h1234_5678);
        idle(2);

        // y1/y2 collision on flag, then sp back-to-back
        drive(1, 4'd9, 32'hAAAA, 2'd1, 32'h5555, 0); cycle();
        chk("flag_y2_wins", back_flag, 32'h5555);
        drive(1, 4'd13, 32'h1111, 2'd2, 32'h2222, 0); cycle();
        drive(1, 4'd13, 32'h3333, 2'd0, 0, 0); cycle();
        idle(1);

        // tlb write protect
        wb.sys_info = 32'h4;
        drive(1, 4'd14, 32'hDEAD, 2'd0, 0, 0); cycle();
        wb.sys_info = 32'h0;
        drive(1, 4'd14, 32'hDEAD, 2'd0, 0, 0); cycle();
        chk("tlb_written", back_tlb, 32'hDEAD);
        idle(1);

        // load with delayed response
        drive(1, 4'd5, 32'hFFFF, 2'd2, 32'h100, 1); cycle();
        idle(3);
        rvalid(32'hCAFE);
        chk("load_r5", back_r5, 32'hCAFE);
        idle(1);

        // minimum-latency load
        drive(1, 4'd7, 0, 2'd0, 0, 1); cycle();
        wb.ex_valid = 0;
        rvalid(32'h7777);
        idle(1);

        // load flushed, stray response ignored
        drive(1, 4'd4, 0, 2'd1, 32'h9, 1); cycle();
        idle(1);
        wb.flush = 1; cycle(); wb.flush = 0;
        idle(1); rvalid(32'hBAD0); idle(1);

        // flush together with response, and flush on an IDLE accept
        drive(1, 4'd6, 0, 2'd0, 0, 1); cycle();
        wb.ex_valid = 0; wb.flush = 1; rvalid(32'hBAD1); wb.flush = 0;
        drive(1, 4'd1, 32'h55, 2'd0, 0, 0); wb.flush = 1; cycle(); wb.flush = 0;
        idle(1);

        // reset during WAIT_MEM with a response in the same cycle
        drive(1, 4'd2, 0, 2'd2, 32'h44, 1); cycle();
        wb.ex_valid = 0; rst = 1; rvalid(32'hBAD2); rst = 0;
        idle(1);

        // codes that never strobe
        drive(1, 4'd0, 32'h1, 2'd3, 32'h2, 0); cycle();
        drive(1, 4'd10, 32'h1, 2'd0, 32'h2, 0); cycle();
        drive(1, 4'd15, 32'h1, 2'd0, 32'h2, 0); cycle();
        idle(1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), $urandom,
                  2'($urandom), $urandom, $urandom_range(0, 3) == 0);
            wb.mem_rvalid = $urandom_range(0, 2) == 0;
            wb.mem_rdata  = $urandom;
            wb.flush      = $urandom_range(0, 19) == 0;
            wb.sys_info   = $urandom;
            rst           = $urandom_range(0, 99) == 0;
            cycle();
        end
        rst = 0; wb.mem_rvalid = 0; wb.flush = 0;
        idle(2);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
